multi_chan_mem_ctrl: RTL and testbench
======================================

MULTI_CHAN_MEM_CTRL -- requirements
Module: multi_chan_mem_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 3, number of input channels (>=2).
REQ-002 SHALL have parameter DW, default 2, beat width in bits.
REQ-003 SHALL have parameter NBEAT, default 4, beats per word (>=2); OW=DW*NBEAT, SW=$clog2(NBEAT+1), CB=NCH*SW.
REQ-004 clock  in  1  single clock, all logic on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 meta_reset  in  1  synchronous clear of coverage map and sum only.
REQ-007 in_valid  in  NCH  per-channel beat valid.
REQ-008 in_data  in  NCH*DW  channel i beat at [i*DW +: DW].
REQ-009 in_ready  out  NCH  per-channel beat accept.
REQ-010 out_valid / out_ready  out / in  1 / 1  word handshake.
REQ-011 out_data  out  OW  assembled word of granted channel.
REQ-012 out_chan  out  $clog2(NCH)  index of granted channel.
REQ-013 coverage  out  NCH*(NBEAT+1)  toggle-coverage bits.
REQ-014 io_cov_sum  out  CB+1  count of distinct joint states visited.
REQ-015 bug  out  1  all channels BUSY simultaneously.

Function
REQ-016 Each channel SHALL hold state 0..NBEAT-1 (READY=0, PENDk=k) or BUSY=NBEAT, SW bits.
REQ-017 in_ready[i] SHALL be 1 iff channel i is not BUSY; beat accepted when in_valid[i] && in_ready[i].
REQ-018 READY+valid -> PEND1, word cleared and beat stored at bits [DW-1:0]; READY+!valid -> stays READY.
REQ-019 PENDk+valid -> beat stored at [k*DW +: DW], next PENDk+1, or BUSY when k=NBEAT-1.
REQ-020 PENDk+!valid -> READY, partial word discarded, no output.
REQ-021 BUSY SHALL hold the word until transferred; transfer = out_valid && out_ready.
REQ-022 out_valid SHALL be 1 iff any channel is BUSY.
REQ-023 Grant SHALL be round-robin: first BUSY channel above last-served pointer, wrapping NCH-1 -> 0.
REQ-024 Grant, out_chan, out_data SHALL stay stable while out_valid && !out_ready (grant locked).
REQ-025 On transfer: granted channel -> READY next cycle, pointer <- out_chan, lock released.
REQ-026 Channels not granted SHALL keep progressing independently during a stall.
REQ-027 bug SHALL be combinational: 1 iff all NCH channels BUSY.
REQ-028 Coverage index SHALL be registered concatenation {ch NCH-1 .. ch0 states}; if its covmap bit is 0, set it and increment io_cov_sum the following cycle.
REQ-029 meta_reset SHALL clear covmap and io_cov_sum, overriding a same-cycle increment.
REQ-030 coverage bit (i*(NBEAT+1)+s), s<NBEAT, SHALL set (sticky) when "channel i in state s" differs from its previous-cycle sample; s=NBEAT tracks in_valid[i].

Reset
REQ-031 reset_n low SHALL immediately set all channels READY, words 0, pointer NCH-1, lock 0, coverage bits and samples 0; hence in_ready all 1, out_valid 0, out_data 0, out_chan 0, bug 0.
REQ-032 covmap and io_cov_sum SHALL NOT be affected by reset_n; simulation-initialised to 0; cleared by meta_reset only.
REQ-033 Reset asserted mid-word or mid-stall SHALL discard all partial and pending words.

Configuration
REQ-034 With MCMC_COVERAGE_EN defined, REQ-028..030 logic SHALL be present.
REQ-035 Without MCMC_COVERAGE_EN, covmap, sum and toggle logic SHALL be absent; coverage and io_cov_sum tied 0; meta_reset ignored; bug retained.

Structure
REQ-036 Package mcmc_pkg SHALL hold the SW/CB width functions and ST_READY constant; BUSY encoding derived from NBEAT locally.
REQ-037 Sub-module toggle_sat_bit SHALL implement one sticky toggle bit (signal, last sample, async clear), instantiated NCH*(NBEAT+1) times.

Verification (defaults NCH=3, DW=2, NBEAT=4)
REQ-038 ch0 beats 1,2,3,0 on four consecutive cycles, out_ready=0 -> BUSY after 4th edge, out_valid=1, out_data=0x39, out_chan=0; out_ready=1 -> ch0 READY, in_ready[0]=1 next cycle.
REQ-039 ch1 two beats then in_valid low -> ch1 READY, out_valid stays 0, bug 0.
REQ-040 all three complete same cycle, out_ready=0 for 5 cycles -> bug=1, out_chan=0 stable; then out_ready=1 -> out_chan 0,1,2 on consecutive transfers, bug 0 after first.
REQ-041 pointer=2, ch0 and ch2 BUSY -> grant ch0 (wrap); after transfer next grant ch2.
REQ-042 idle 3 cycles after reset -> io_cov_sum=1; meta_reset -> 0; reset_n pulse mid-word -> out_valid 0 immediately, io_cov_sum unchanged; without MCMC_COVERAGE_EN coverage=0, io_cov_sum=0 throughout.

Source files
------------

// File: rtl/mcmc_pkg.sv
// Shared widths and state constants for the multi-channel word assembler.
package mcmc_pkg;

   localparam int ST_READY = 0;

   function automatic int sw_f(input int nbeat);
      return $clog2(nbeat + 1);
   endfunction

   function automatic int cb_f(input int nch, input int nbeat);
      return nch * sw_f(nbeat);
   endfunction

endpackage

// File: rtl/toggle_sat_bit.sv
// One sticky toggle-coverage bit: sets once its signal differs from last cycle.
// Only built when MCMC_COVERAGE_EN is defined.
`ifdef MCMC_COVERAGE_EN
module toggle_sat_bit (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_cov
);

   logic r_last;
   logic r_cov;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= 1'b0;
         r_cov  <= 1'b0;
      end else begin
         r_last <= i_sig;
         if (i_sig != r_last) r_cov <= 1'b1;
      end
   end

   assign o_cov = r_cov;

endmodule
`endif

// File: rtl/multi_chan_mem_ctrl.sv
// Per-channel beat assembly with round-robin word output.
// MCMC_COVERAGE_EN adds joint-state and toggle coverage.
module multi_chan_mem_ctrl
   import mcmc_pkg::*;
#(
   parameter int NCH   = 3,
   parameter int DW    = 2,
   parameter int NBEAT = 4
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         meta_reset,
   input  logic [NCH-1:0]               in_valid,
   input  logic [NCH*DW-1:0]            in_data,
   output logic [NCH-1:0]               in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DW*NBEAT-1:0]          out_data,
   output logic [$clog2(NCH)-1:0]       out_chan,
   output logic [NCH*(NBEAT+1)-1:0]     coverage,
   output logic [cb_f(NCH, NBEAT):0]    io_cov_sum,
   output logic                         bug
);

   localparam int OW = DW * NBEAT;
   localparam int SW = sw_f(NBEAT);
   localparam int CB = cb_f(NCH, NBEAT);
   localparam int CW = $clog2(NCH);
   localparam logic [SW-1:0] ST_RDY  = SW'(ST_READY);
   localparam logic [SW-1:0] ST_BUSY = SW'(NBEAT);

   logic [NCH*SW-1:0] w_st;
   logic [NCH*OW-1:0] w_word;
   logic [NCH-1:0]    w_busy;
   logic [CW-1:0]     r_ptr;
   logic [CW-1:0]     r_gnt;
   logic [CW-1:0]     w_rr;
   logic [CW-1:0]     w_gnt;
   logic              r_lock;
   logic              w_xfer;
   int                w_best;
   int                w_dist;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [SW-1:0] r_st;
      logic [OW-1:0] r_word;
      logic [DW-1:0] w_beat;

      assign w_beat = in_data[i*DW +: DW];

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_st   <= ST_RDY;
            r_word <= '0;
         end else if (r_st == ST_BUSY) begin
            if (w_xfer && w_gnt == CW'(i)) r_st <= ST_RDY;
         end else if (!in_valid[i]) begin
            r_st <= ST_RDY;
         end else if (r_st == ST_RDY) begin
            r_word <= OW'(w_beat);
            r_st   <= SW'(1);
         end else begin
            for (int k = 1; k < NBEAT; k++) begin
               if (r_st == SW'(k)) r_word[k*DW +: DW] <= w_beat;
            end
            r_st <= r_st + SW'(1);
         end
      end

      assign w_st[i*SW +: SW]   = r_st;
      assign w_word[i*OW +: OW] = r_word;
      assign w_busy[i]          = (r_st == ST_BUSY);
   end

   // distance 0 is the channel just above the last-served pointer
   always_comb begin
      w_rr   = '0;
      w_best = NCH;
      w_dist = 0;
      for (int j = 0; j < NCH; j++) begin
         w_dist = (j + NCH - 1 - int'(r_ptr)) % NCH;
         if (w_busy[j] && w_dist < w_best) begin
            w_best = w_dist;
            w_rr   = CW'(j);
         end
      end
   end

   assign w_gnt     = r_lock ? r_gnt : w_rr;
   assign out_valid = |w_busy;
   assign w_xfer    = out_valid & out_ready;
   assign out_chan  = out_valid ? w_gnt : '0;
   assign in_ready  = ~w_busy;
   assign bug       = &w_busy;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr  <= CW'(NCH - 1);
         r_gnt  <= '0;
         r_lock <= 1'b0;
      end else if (w_xfer) begin
         r_ptr  <= w_gnt;
         r_lock <= 1'b0;
      end else if (out_valid) begin
         r_gnt  <= w_gnt;
         r_lock <= 1'b1;
      end
   end

   always_comb begin
      out_data = '0;
      for (int j = 0; j < NCH; j++) begin
         if (out_valid && w_gnt == CW'(j)) out_data = w_word[j*OW +: OW];
      end
   end

`ifdef MCMC_COVERAGE_EN
   // covmap and sum survive reset_n; only meta_reset clears them
   logic [CB-1:0]       r_cov_idx = '0;
   logic [(2**CB)-1:0]  r_covmap  = '0;
   logic [CB:0]         r_sum     = '0;

   always_ff @(posedge clock) begin
      r_cov_idx <= w_st;
      if (meta_reset) begin
         r_covmap <= '0;
         r_sum    <= '0;
      end else if (!r_covmap[r_cov_idx]) begin
         r_covmap[r_cov_idx] <= 1'b1;
         r_sum               <= r_sum + (CB+1)'(1);
      end
   end

   assign io_cov_sum = r_sum;

   for (genvar i = 0; i < NCH; i++) begin : g_cov
      for (genvar s = 0; s <= NBEAT; s++) begin : g_bit
         logic w_sig;
         if (s < NBEAT) begin : g_st
            assign w_sig = (w_st[i*SW +: SW] == SW'(s));
         end else begin : g_vld
            assign w_sig = in_valid[i];
         end
         toggle_sat_bit u_tog (
            .i_clk   (clock),
            .i_rst_n (reset_n),
            .i_sig   (w_sig),
            .o_cov   (coverage[i*(NBEAT+1)+s])
         );
      end
   end
`else
   logic w_unused;
   assign w_unused   = ^{meta_reset, w_st};
   assign coverage   = '0;
   assign io_cov_sum = '0;
`endif

endmodule

// File: tb/tb_multi_chan_mem_ctrl.sv
// Directed bench for multi_chan_mem_ctrl with a transfer scoreboard.
module tb_multi_chan_mem_ctrl;

`ifdef MCMC_COVERAGE_EN
   localparam bit COV = 1'b1;
`else
   localparam bit COV = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        meta_reset;
   logic [2:0]  in_valid;
   logic [5:0]  in_data;
   logic [2:0]  in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_chan;
   logic [14:0] coverage;
   logic [9:0]  io_cov_sum;
   logic        bug;

   typedef struct {
      logic [1:0] chan;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   multi_chan_mem_ctrl dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .meta_reset (meta_reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_chan   (out_chan),
      .coverage   (coverage),
      .io_cov_sum (io_cov_sum),
      .bug        (bug)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [2:0] v, input logic [1:0] d0,
                        input logic [1:0] d1, input logic [1:0] d2);
      in_valid = v;
      in_data  = {d2, d1, d0};
   endtask

   task automatic push(input logic [1:0] c, input logic [7:0] d);
      exp_t e;
      e.chan = c;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      n_chk++;
      assert (sb.size() != 0) else begin
         n_err++;
         $error("FAIL %s_empty: observed 0 expected entries", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_chan"}, 32'(out_chan), 32'(e.chan));
         chk({tag, "_data"}, 32'(out_data), 32'(e.data));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      meta_reset = 1'b0;
      out_ready  = 1'b0;
      drive(3'b000, 0, 0, 0);
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'h7);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_chan", 32'(out_chan), 32'h0);
      chk("rst_bug", 32'(bug), 32'h0);
      chk("rst_coverage", 32'(coverage), 32'h0);

      reset_n = 1'b1;
      repeat (3) tick();
      chk("idle_sum", 32'(io_cov_sum), COV ? 32'd1 : 32'd0);
      chk("idle_toggle", 32'(coverage), COV ? 32'h421 : 32'h0);

      meta_reset = 1'b1;
      tick();
      meta_reset = 1'b0;
      chk("meta_sum", 32'(io_cov_sum), 32'd0);
      tick();
      chk("meta_resum", 32'(io_cov_sum), COV ? 32'd1 : 32'd0);

      // ch0 word 0x39 with a stall before transfer
      drive(3'b001, 1, 0, 0); tick();
      drive(3'b001, 2, 0, 0); tick();
      drive(3'b001, 3, 0, 0); tick();
      chk("w1_notyet", 32'(out_valid), 32'h0);
      drive(3'b001, 0, 0, 0); tick();
      push(2'd0, 8'h39);
      drive(3'b000, 0, 0, 0);
      chk("w1_in_ready", 32'(in_ready), 32'h6);
      tick();
      tick();
      chk("w1_stall_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      pop_chk("w1");
      tick();
      out_ready = 1'b0;
      chk("w1_done_ready", 32'(in_ready), 32'h7);
      chk("w1_done_valid", 32'(out_valid), 32'h0);

      // ch1 partial word discarded, then a fresh full word
      drive(3'b010, 0, 1, 0); tick();
      drive(3'b010, 0, 2, 0); tick();
      drive(3'b000, 0, 0, 0); tick();
      chk("part_in_ready", 32'(in_ready), 32'h7);
      chk("part_valid", 32'(out_valid), 32'h0);
      chk("part_bug", 32'(bug), 32'h0);
      drive(3'b010, 0, 2, 0); tick();
      drive(3'b010, 0, 1, 0); tick();
      drive(3'b010, 0, 0, 0); tick();
      chk("fresh_notyet", 32'(out_valid), 32'h0);
      drive(3'b010, 0, 3, 0); tick();
      push(2'd1, 8'hC6);
      drive(3'b000, 0, 0, 0);
      out_ready = 1'b1;
      pop_chk("fresh");
      tick();
      out_ready = 1'b0;

      // reset during a stall
      drive(3'b001, 1, 0, 0); tick();
      drive(3'b001, 1, 0, 0); tick();
      drive(3'b001, 1, 0, 0); tick();
      drive(3'b001, 1, 0, 0); tick();
      drive(3'b000, 0, 0, 0);
      tick();
      chk("stall_valid", 32'(out_valid), 32'h1);
      meta_reset = 1'b1;
      tick();
      meta_reset = 1'b0;
      tick();
      chk("stall_sum", 32'(io_cov_sum), COV ? 32'd1 : 32'd0);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_ready", 32'(in_ready), 32'h7);
      chk("mid_rst_data", 32'(out_data), 32'h0);
      chk("mid_rst_sum", 32'(io_cov_sum), COV ? 32'd1 : 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      chk("post_rst_sum", 32'(io_cov_sum), COV ? 32'd2 : 32'd0);
      chk("post_rst_valid", 32'(out_valid), 32'h0);

      // all three channels finish together
      drive(3'b111, 0, 3, 1); tick();
      drive(3'b111, 1, 2, 1); tick();
      drive(3'b111, 2, 1, 1); tick();
      drive(3'b111, 3, 0, 1); tick();
      push(2'd0, 8'hE4);
      push(2'd1, 8'h1B);
      push(2'd2, 8'h55);
      drive(3'b000, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         chk("all_bug", 32'(bug), 32'h1);
         chk("all_chan", 32'(out_chan), 32'h0);
         tick();
      end
      out_ready = 1'b1;
      pop_chk("all0");
      tick();
      chk("all_bug_clr", 32'(bug), 32'h0);
      pop_chk("all1");
      tick();
      pop_chk("all2");
      tick();
      out_ready = 1'b0;
      chk("all_empty", 32'(out_valid), 32'h0);

      // pointer at 2: ch0 wins by wrap, then ch2
      drive(3'b101, 3, 0, 0); tick();
      drive(3'b101, 0, 0, 2); tick();
      drive(3'b101, 0, 0, 0); tick();
      drive(3'b101, 1, 0, 2); tick();
      push(2'd0, 8'h43);
      push(2'd2, 8'h88);
      drive(3'b000, 0, 0, 0);
      out_ready = 1'b1;
      pop_chk("wrap0");
      tick();
      pop_chk("wrap2");
      tick();
      out_ready = 1'b0;

      // ch1 grant locked while ch0 completes during the stall
      drive(3'b010, 0, 2, 0); tick();
      drive(3'b010, 0, 0, 0); tick();
      drive(3'b010, 0, 1, 0); tick();
      drive(3'b010, 0, 0, 0); tick();
      drive(3'b000, 0, 0, 0);
      tick();
      chk("lock_chan", 32'(out_chan), 32'h1);
      drive(3'b001, 1, 0, 0); tick();
      drive(3'b001, 1, 0, 0); tick();
      drive(3'b001, 0, 0, 0); tick();
      drive(3'b001, 0, 0, 0); tick();
      drive(3'b000, 0, 0, 0);
      push(2'd1, 8'h12);
      push(2'd0, 8'h05);
      chk("lock_hold_chan", 32'(out_chan), 32'h1);
      chk("lock_hold_data", 32'(out_data), 32'h12);
      chk("lock_in_ready", 32'(in_ready), 32'h4);
      chk("lock_bug", 32'(bug), 32'h0);
      out_ready = 1'b1;
      pop_chk("lock1");
      tick();
      pop_chk("lock0");
      tick();
      out_ready = 1'b0;
      chk("end_valid", 32'(out_valid), 32'h0);
      chk("end_ready", 32'(in_ready), 32'h7);
      chk("end_sb", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
